// File: rtl/alu_uart_frontend.sv
// Sequencer between a UART RX/TX pair and a combinational ALU: gathers A, B, opcode,
// registers them to the ALU, captures the result and strobes it into the transmitter.
// Optional inter-byte timeout is built only when ALU_FE_TIMEOUT_EN is defined.

module alu_uart_frontend #(
   parameter int DATA_W      = 8,
   parameter int OP_W        = 6,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [DATA_W-1:0] i_rx_data,
   input  logic              i_rx_done,
   input  logic              i_tx_done,
   input  logic [DATA_W-1:0] i_alu_res,
   output logic [DATA_W-1:0] o_alu_a,
   output logic [DATA_W-1:0] o_alu_b,
   output logic [OP_W-1:0]   o_alu_op,
   output logic [DATA_W-1:0] o_tx_data,
   output logic              o_tx_start,
   output logic              o_busy,
   output logic              o_timeout
);

   typedef enum logic [2:0] {
      S_A,
      S_B,
      S_OP,
      S_EXEC,
      S_SEND,
      S_WAIT_TX
   } state_t;

   state_t state;
   logic   timeout_hit;
   logic   waiting_byte;

   // Only the low OP_W bits of the opcode byte reach the ALU.
   logic unused_op_bits;
   assign unused_op_bits = ^i_rx_data[DATA_W-1:OP_W];

   assign waiting_byte = (state == S_B) || (state == S_OP);

   // Main sequencer: operands, result and strobes are all registered here.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= S_A;
         o_alu_a    <= '0;
         o_alu_b    <= '0;
         o_alu_op   <= '0;
         o_tx_data  <= '0;
         o_tx_start <= 1'b0;
         o_busy     <= 1'b0;
      end else begin
         o_tx_start <= 1'b0;
         case (state)
            S_A: begin
               if (i_rx_done) begin
                  o_alu_a <= i_rx_data;
                  state   <= S_B;
               end
            end
            S_B: begin
               if (i_rx_done) begin
                  o_alu_b <= i_rx_data;
                  state   <= S_OP;
               end else if (timeout_hit) begin
                  state <= S_A;
               end
            end
            S_OP: begin
               if (i_rx_done) begin
                  o_alu_op <= i_rx_data[OP_W-1:0];
                  o_busy   <= 1'b1;
                  state    <= S_EXEC;
               end else if (timeout_hit) begin
                  state <= S_A;
               end
            end
            S_EXEC: begin
               o_tx_data  <= i_alu_res;
               o_tx_start <= 1'b1;
               state      <= S_SEND;
            end
            S_SEND: begin
               state <= S_WAIT_TX;
            end
            S_WAIT_TX: begin
               if (i_tx_done) begin
                  o_busy <= 1'b0;
                  state  <= S_A;
               end
            end
            default: begin
               state  <= S_A;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

`ifdef ALU_FE_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   logic [CNT_W-1:0] timeout_cnt;
   logic             timeout_q;

   // A byte arriving on the terminal count wins over the timeout.
   assign timeout_hit = waiting_byte && !i_rx_done &&
                        (timeout_cnt == CNT_W'(TIMEOUT_CYC - 1));

   // Counter is held at zero outside S_B/S_OP, so entering either state starts from 0.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         timeout_cnt <= '0;
         timeout_q   <= 1'b0;
      end else begin
         timeout_q <= timeout_hit;
         if (!waiting_byte || i_rx_done || timeout_hit) begin
            timeout_cnt <= '0;
         end else begin
            timeout_cnt <= timeout_cnt + CNT_W'(1);
         end
      end
   end

   assign o_timeout = timeout_q;
`else
   // TIMEOUT_CYC only matters when the timeout logic is built.
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYC == 0) ^ waiting_byte;
   assign timeout_hit        = 1'b0;
   assign o_timeout          = 1'b0;
`endif

endmodule

// File: tb/tb_alu_uart_frontend.sv
// Directed bench for alu_uart_frontend: table of full frames plus hand sequences for
// dropped bytes, mid-frame reset and the optional inter-byte timeout.

module tb_alu_uart_frontend;

   localparam int DATA_W = 8;
   localparam int OP_W   = 6;

   logic              clk;
   logic              rst_n;
   logic [DATA_W-1:0] rx_data;
   logic              rx_done;
   logic              tx_done;
   logic [DATA_W-1:0] alu_res;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [OP_W-1:0]   alu_op;
   logic [DATA_W-1:0] tx_data;
   logic              tx_start;
   logic              busy;
   logic              timeout;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] op;
      logic [7:0] expected;
      bit         inject_drop;
   } frame_t;

   alu_uart_frontend #(
      .DATA_W     (DATA_W),
      .OP_W       (OP_W),
      .TIMEOUT_CYC(16)
   ) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_rx_data (rx_data),
      .i_rx_done (rx_done),
      .i_tx_done (tx_done),
      .i_alu_res (alu_res),
      .o_alu_a   (alu_a),
      .o_alu_b   (alu_b),
      .o_alu_op  (alu_op),
      .o_tx_data (tx_data),
      .o_tx_start(tx_start),
      .o_busy    (busy),
      .o_timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural stand-in for the combinational ALU.
   always_comb begin
      alu_res = 8'h00;
      case (alu_op)
         6'h20:   alu_res = alu_a + alu_b;
         6'h22:   alu_res = alu_a - alu_b;
         6'h24:   alu_res = alu_a & alu_b;
         default: alu_res = 8'h00;
      endcase
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drives a single-cycle rx_done pulse; returns at the negedge after the sampling edge.
   task automatic applyStimulus(input logic [7:0] data);
      @(negedge clk);
      rx_data = data;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
   endtask

   task automatic pulseTxDone();
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
   endtask

   // Sends the opcode byte and checks the N+1 / N+2 / N+3 timing and TX handshake.
   task automatic finishFrame(input logic [7:0] a, input logic [7:0] op,
                              input logic [7:0] expected, input bit inject_drop);
      applyStimulus(op);
      checkOutput("start_low_n1", tx_start, 0);
      checkOutput("busy_exec", busy, 1);
      checkOutput("alu_op", alu_op, op & 8'h3F);
      @(negedge clk);
      checkOutput("start_high_n2", tx_start, 1);
      checkOutput("tx_data_n2", tx_data, expected);
      @(negedge clk);
      checkOutput("start_low_n3", tx_start, 0);
      checkOutput("busy_wait_tx", busy, 1);
      if (inject_drop) begin
         applyStimulus(8'h55);
         checkOutput("drop_alu_a", alu_a, a);
         checkOutput("drop_busy", busy, 1);
      end
      pulseTxDone();
      checkOutput("busy_after_tx", busy, 0);
      checkOutput("tx_data_held", tx_data, expected);
      checkOutput("alu_a_held", alu_a, a);
   endtask

   task automatic runFrame(input frame_t f);
      applyStimulus(f.a);
      applyStimulus(f.b);
      checkOutput("alu_b", alu_b, f.b);
      finishFrame(f.a, f.op, f.expected, f.inject_drop);
   endtask

   initial begin
      frame_t frames[6];
      int     timeout_pulses;
      int     start_pulses;

      frames[0] = '{8'h01, 8'h00, 8'h20, 8'h01, 1'b0};
      frames[1] = '{8'h0F, 8'h05, 8'h22, 8'h0A, 1'b0};
      frames[2] = '{8'h30, 8'h96, 8'h22, 8'h9A, 1'b0};
      frames[3] = '{8'h8F, 8'hAA, 8'h24, 8'h8A, 1'b1};
      frames[4] = '{8'h06, 8'h01, 8'h20, 8'h07, 1'b0};
      frames[5] = '{8'hFA, 8'hB3, 8'hE4, 8'hB2, 1'b0};

      rst_n   = 1'b0;
      rx_data = 8'h00;
      rx_done = 1'b0;
      tx_done = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_alu_a", alu_a, 0);
      checkOutput("rst_tx_start", tx_start, 0);
      checkOutput("rst_busy", busy, 0);
      rst_n = 1'b1;

      // A stray tx_done while idle must not disturb the next frame.
      @(negedge clk);
      pulseTxDone();

      for (int i = 0; i < 6; i++) begin
         runFrame(frames[i]);
      end

      // Reset in the middle of a frame returns everything to zero.
      applyStimulus(8'h10);
      applyStimulus(8'h20);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_alu_a", alu_a, 0);
      checkOutput("midrst_alu_b", alu_b, 0);
      checkOutput("midrst_alu_op", alu_op, 0);
      checkOutput("midrst_tx_data", tx_data, 0);
      checkOutput("midrst_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      runFrame('{8'hFA, 8'hB3, 8'h24, 8'hB2, 1'b0});

      // Partial frame followed by a long idle gap.
      applyStimulus(8'h11);
      timeout_pulses = 0;
      start_pulses   = 0;
      for (int c = 0; c < 24; c++) begin
         if (timeout === 1'b1) timeout_pulses++;
         if (tx_start === 1'b1) start_pulses++;
         @(negedge clk);
      end
      checkOutput("idle_tx_start", start_pulses, 0);
      checkOutput("idle_alu_a", alu_a, 8'h11);
`ifdef ALU_FE_TIMEOUT_EN
      checkOutput("timeout_pulses", timeout_pulses, 1);
      runFrame('{8'h06, 8'h01, 8'h20, 8'h07, 1'b0});
`else
      checkOutput("timeout_pulses", timeout_pulses, 0);
      applyStimulus(8'h05);
      finishFrame(8'h11, 8'h20, 8'h16, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
